keypad_tx_ctrl: RTL and testbench
=================================

Name: keypad_tx_ctrl

Overview:
- Parametrised successor to the switch/button character source feeding the UART serializer (`cereal`).
- Synchronises and debounces the send button, then encodes the switch nibble to ASCII. Mode is decimal+'U' or full hex.
- Each press, plus optional auto-repeat, is queued in a small character FIFO.
- Characters drain to the serializer over a start/busy handshake with a timeout.

Parameters:
- DEB_CYCLES, 100000: cycles the synchronised button must be stable before the debounced level changes.
- HEX_MODE, 0: 0 = codes 0-9 map to '0'-'9', 15 maps to 'U', 10-14 are invalid. 1 = codes 0-15 map to '0'-'9','A'-'F'.
- REPEAT_EN, 0: 1 enables auto-repeat while the button is held.
- REPEAT_DELAY, 50000000: cycles from a press event to the first repeat event.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat events.
- FIFO_DEPTH, 8: character FIFO entries; must be a power of 2 and at least 2.
- START_HOLD, 5702: maximum cycles start is held waiting for the serializer ack.

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  character select, asynchronous, sw[0] = LSB
- btn  in  1  raw send button, asynchronous, active-high
- tx_busy  in  1  serializer busy, synchronous to sysclk
- data  out  8  ASCII character to serializer, registered
- start  out  1  transmit request, registered
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  one-cycle pulse: a valid event was dropped because the FIFO was full
- invalid  out  1  one-cycle pulse: an event carried an unmapped code
- tx_timeout  out  1  one-cycle pulse: start was held START_HOLD cycles without ack

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs return to 0; data = 8'h00.
  - FIFO is emptied; debounce and repeat counters clear; debounced level = 0; FSM = IDLE.
- Input synchronisation:
  - btn and sw each pass through a 2-FF synchroniser.
  - Debounced level changes only after the synchronised btn has differed from it for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- Events:
  - A press event fires on the debounced 0->1 edge.
  - If REPEAT_EN=1 and the level stays 1, a repeat event fires REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - Release (1->0) stops repeats immediately and clears the repeat counter.
- Encode: the synchronised sw is sampled in the event cycle and mapped per HEX_MODE.
  - An unmapped code pulses invalid and pushes nothing.
- FIFO push/pop:
  - A valid event pushes the character 1 cycle after the event cycle.
  - Push while full is dropped and pulses overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and counts from 0 to FIFO_DEPTH.
- Transmit FSM:
  - IDLE: if FIFO not empty and tx_busy=0, pop the head into data, set start=1, go to START. data is stable from this cycle until the next pop.
  - START: start stays 1.
    - If tx_busy=1 (ack): start=0, go to BUSY.
    - Else, once START_HOLD cycles have elapsed in START: start=0, pulse tx_timeout, go to IDLE. The character is discarded, not retried.
  - BUSY: when tx_busy=0, go to IDLE. The next start is asserted no earlier than 1 cycle later.
  - tx_busy=1 while in IDLE blocks the pop.
- Latency:
  - First start rises 3 cycles after the press event on an empty FIFO (sync-to-encode, push, pop/launch).
- Reset mid-operation: start drops asynchronously; queued characters are lost.

Decomposition:
- Shared package kb_pkg:
  - ASCII constants ASCII_0=8'h30, ASCII_A=8'h41, ASCII_U=8'h55.
  - Code constant CODE_U=4'hF.
  - TX FSM state enum {IDLE, START, BUSY}.
- One natural sub-module: sync_debounce, covering the 2-FF synchroniser, stable counter and rise/fall pulses, parametrised by DEB_CYCLES. It is reusable for other buttons.
- The FIFO, encoder, repeat timer and TX FSM stay inline.

Test Plan (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4, START_HOLD=10; the serializer model raises tx_busy 2 cycles after start and holds it 12 cycles):
- Single press, sw=4'b0101, HEX_MODE=0 -> exactly one start, data=8'h35; start is held until tx_busy rises; no repeat.
- Bouncy btn (toggles every 2 cycles for 20 cycles, then stays high) -> exactly one press event; data=8'h30 for sw=0.
- sw=4'hC: HEX_MODE=0 -> invalid pulse and no start. HEX_MODE=1 -> data=8'h43 ('C'). sw=4'hF with HEX_MODE=0 -> data=8'h55.
- REPEAT_EN=1, btn held 60 cycles after debounce, tx_busy forced high -> events at +0, +20, +28, +36, +44, +52. fifo_level saturates at 4. The 5th and 6th events each pulse overflow.
- Serializer never raises tx_busy -> start is high for exactly 10 cycles, tx_timeout pulses once, then the FSM pops the next entry.
- rst_n pulled low in START with 2 entries queued -> start=0 and fifo_level=0 in the same cycle; no start after release until a new press.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared definitions for the keypad character source.
//   DATA_W      : width of one character on the serializer interface
//   ASCII_*     : base characters used by the nibble encoder
//   CODE_U      : switch code that maps to 'U' in decimal mode
//   tx_state_e  : transmit handshake states
package kb_pkg;

  localparam int          DATA_W  = 8;
  localparam logic [7:0]  ASCII_0 = 8'h30;
  localparam logic [7:0]  ASCII_A = 8'h41;
  localparam logic [7:0]  ASCII_U = 8'h55;
  localparam logic [3:0]  CODE_U  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } tx_state_e;

endpackage

// File: rtl/keypad_tx_ctrl_sync_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and edge pulses.
// The debounced level follows the synchronised input only after the input has
// disagreed with it for DEB_CYCLES consecutive cycles.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button
//   level_o : debounced level
//   rise_o  : one-cycle pulse in the first cycle level_o reads 1
//   fall_o  : one-cycle pulse in the first cycle level_o reads 0
module sync_debounce #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = s2_q;
      else                              cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/keypad_tx_ctrl.sv
// Keypad character source for the UART serializer.
// A debounced button press (plus optional auto-repeat) samples the switch
// nibble, encodes it to ASCII, queues it in a small FIFO and hands it to the
// serializer over a start/busy handshake with a bounded wait for the ack.
//   sysclk     : clock
//   rst_n      : asynchronous active-low reset
//   sw         : switch nibble, asynchronous
//   btn        : raw send button, asynchronous, active-high
//   tx_busy    : serializer busy / ack
//   data       : character presented to the serializer
//   start      : transmit request
//   fifo_level : FIFO occupancy, 0..FIFO_DEPTH
//   overflow   : pulse, valid character dropped on a full FIFO
//   invalid    : pulse, event carried an unmapped code
//   tx_timeout : pulse, start abandoned after START_HOLD cycles without ack
module keypad_tx_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 100000,
  parameter int unsigned HEX_MODE      = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned START_HOLD    = 5702
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic [3:0]                    sw,
  input  logic                          btn,
  input  logic                          tx_busy,
  output logic [DATA_W-1:0]             data,
  output logic                          start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          invalid,
  output logic                          tx_timeout
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int HW      = $clog2(START_HOLD + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  // {valid, character}
  function automatic logic [DATA_W:0] encode(input logic [3:0] code);
    logic [DATA_W:0] r;
    r = '0;
    if (code <= 4'd9)       r = {1'b1, ASCII_0 + {4'h0, code}};
    else if (HEX_MODE != 0) r = {1'b1, ASCII_A + {4'h0, code} - 8'd10};
    else if (code == CODE_U) r = {1'b1, ASCII_U};
    return r;
  endfunction

  logic            deb_level, deb_rise, deb_fall;
  logic [3:0]      sw_s1_q, sw_s2_q;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;
  logic            rpt_evt;
  logic            ev_p0;
  logic [DATA_W:0] enc_p0;
  logic            vld_p1, invalid_q;
  logic [DATA_W-1:0] char_p1;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            fifo_full, fifo_empty, push_ok, pop, overflow_q;
  tx_state_e       state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            start_q, start_d, tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .btn_i   (btn),
    .level_o (deb_level),
    .rise_o  (deb_rise),
    .fall_o  (deb_fall)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // rpt_cnt_q holds the number of cycles since the last event while held.
  always_comb begin
    rpt_evt     = 1'b0;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    if (REPEAT_EN != 0) begin
      if (deb_rise) begin
        rpt_cnt_d   = RW'(1);
        rpt_first_d = 1'b1;
      end else if (deb_fall) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
      end else if (deb_level) begin
        if (rpt_cnt_q == (rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
          rpt_evt     = 1'b1;
          rpt_cnt_d   = RW'(1);
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  // ---- stage p0: event cycle, switch sampled and encoded ----
  assign ev_p0  = deb_rise | rpt_evt;
  assign enc_p0 = encode(sw_s2_q);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      vld_p1    <= ev_p0 & enc_p0[DATA_W];
      invalid_q <= ev_p0 & ~enc_p0[DATA_W];
    end
  end

  always_ff @(posedge sysclk) begin
    char_p1 <= enc_p0[DATA_W-1:0];
  end

  // ---- stage p1: push into FIFO ----
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push_ok    = vld_p1 & ~fifo_full;

  always_comb begin
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= char_p1;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= vld_p1 & fifo_full;
    end
  end

  // ---- stage p2: pop and launch to serializer ----
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    start_d = start_q;
    data_d  = data_q;
    tmo_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          start_d = 1'b1;
          hold_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = BUSY;
        end else if (hold_q == HW'(START_HOLD - 1)) begin
          // No ack in time: the character is dropped, not retried.
          start_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      BUSY: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
    end
  end

  assign data       = data_q;
  assign start      = start_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign invalid    = invalid_q;
  assign tx_timeout = tmo_q;

endmodule

// File: tb/tb_keypad_tx_ctrl.sv
// Directed bench for keypad_tx_ctrl: a decimal/auto-repeat build and a hex
// build share the button and switch inputs; each has its own serializer model.
module tb_keypad_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic [1:0] busy;

  logic [7:0] data_a, data_h;
  logic       start_a, start_h;
  logic [2:0] lvl_a, lvl_h;
  logic       ovf_a, ovf_h, inv_a, inv_h, tmo_a, tmo_h;

  always #5 clk = ~clk;

  keypad_tx_ctrl #(
    .DEB_CYCLES(4), .HEX_MODE(0), .REPEAT_EN(1), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8), .FIFO_DEPTH(4), .START_HOLD(10)
  ) dut_a (
    .sysclk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .tx_busy(busy[0]),
    .data(data_a), .start(start_a), .fifo_level(lvl_a), .overflow(ovf_a),
    .invalid(inv_a), .tx_timeout(tmo_a)
  );

  keypad_tx_ctrl #(
    .DEB_CYCLES(4), .HEX_MODE(1), .REPEAT_EN(0), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8), .FIFO_DEPTH(4), .START_HOLD(10)
  ) dut_h (
    .sysclk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .tx_busy(busy[1]),
    .data(data_h), .start(start_h), .fifo_level(lvl_h), .overflow(ovf_h),
    .invalid(inv_h), .tx_timeout(tmo_h)
  );

  // Serializer model. bmode: 0 = ack 2 cycles after start, busy 12 cycles;
  // 1 = busy forced high; 2 = never busy.
  int         bmode;
  int         dly [2];
  int         bcnt [2];
  logic [1:0] strt;
  logic [1:0] strt_prev;
  logic [7:0] dat [2];
  logic [1:0] inv_v, ovf_v, tmo_v;

  assign strt   = {start_h, start_a};
  assign dat[0] = data_a;
  assign dat[1] = data_h;
  assign inv_v  = {inv_h, inv_a};
  assign ovf_v  = {ovf_h, ovf_a};
  assign tmo_v  = {tmo_h, tmo_a};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        dly[i]  <= 0;
        bcnt[i] <= 0;
        busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bmode == 1) begin
          busy[i] <= 1'b1;
        end else if (bmode == 2) begin
          busy[i] <= 1'b0;
          dly[i]  <= 0;
          bcnt[i] <= 0;
        end else if (bcnt[i] != 0) begin
          bcnt[i] <= bcnt[i] - 1;
          busy[i] <= (bcnt[i] != 1);
        end else if (dly[i] != 0) begin
          dly[i]  <= 0;
          busy[i] <= 1'b1;
          bcnt[i] <= 12;
        end else begin
          busy[i] <= 1'b0;
          if (strt[i]) dly[i] <= 1;
        end
      end
    end
  end

  // Event monitor: start rises, character at each rise, pulse counts.
  int         nstart [2];
  logic [7:0] lastd [2];
  int         ninv [2];
  int         novf [2];
  int         ntmo [2];

  always @(posedge clk) begin
    strt_prev <= strt;
    for (int i = 0; i < 2; i++) begin
      if (strt[i] && !strt_prev[i]) begin
        nstart[i] <= nstart[i] + 1;
        lastd[i]  <= dat[i];
      end
      if (inv_v[i]) ninv[i] <= ninv[i] + 1;
      if (ovf_v[i]) novf[i] <= novf[i] + 1;
      if (tmo_v[i]) ntmo[i] <= ntmo[i] + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int gap);
    btn = 1'b1;
    ticks(hold);
    btn = 1'b0;
    ticks(gap);
  endtask

  typedef struct {
    logic [3:0] sw;
    int         a_starts;
    logic [7:0] a_data;
    int         a_inv;
    logic [7:0] h_data;
  } enc_vec_t;

  typedef struct {
    int         t;
    logic [2:0] lvl;
    logic       ovf;
  } rpt_vec_t;

  enc_vec_t ev [5];
  rpt_vec_t rv [14];

  initial begin
    int b0, b1, i0, i1, o0, t0, cnt, idx;

    ev[0] = '{4'hC, 0, 8'h00, 1, 8'h43};
    ev[1] = '{4'hF, 1, 8'h55, 0, 8'h46};
    ev[2] = '{4'h9, 1, 8'h39, 0, 8'h39};
    ev[3] = '{4'hA, 0, 8'h00, 1, 8'h41};
    ev[4] = '{4'h3, 1, 8'h33, 0, 8'h33};

    rv[0]  = '{7,  3'd0, 1'b0};
    rv[1]  = '{8,  3'd1, 1'b0};
    rv[2]  = '{27, 3'd1, 1'b0};
    rv[3]  = '{28, 3'd2, 1'b0};
    rv[4]  = '{35, 3'd2, 1'b0};
    rv[5]  = '{36, 3'd3, 1'b0};
    rv[6]  = '{43, 3'd3, 1'b0};
    rv[7]  = '{44, 3'd4, 1'b0};
    rv[8]  = '{51, 3'd4, 1'b0};
    rv[9]  = '{52, 3'd4, 1'b1};
    rv[10] = '{53, 3'd4, 1'b0};
    rv[11] = '{60, 3'd4, 1'b1};
    rv[12] = '{61, 3'd4, 1'b0};
    rv[13] = '{70, 3'd4, 1'b0};

    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = 4'h0;
    bmode = 0;
    ticks(3);
    chk("rst_data", {24'h0, data_a}, 32'h00);
    chk("rst_start", {31'h0, start_a}, 32'h0);
    chk("rst_level", {29'h0, lvl_a}, 32'h0);
    chk("rst_pulses", {29'h0, ovf_a, inv_a, tmo_a}, 32'h0);
    rst_n = 1'b1;

    // Single press, sw=5: push 2 cycles after the event, start 1 cycle later.
    sw = 4'h5;
    ticks(4);
    b0 = nstart[0];
    b1 = nstart[1];
    btn = 1'b1;
    ticks(8);
    chk("single_level_push", {29'h0, lvl_a}, 32'd1);
    chk("single_start_early", {31'h0, start_a}, 32'h0);
    ticks(1);
    chk("single_start_rise", {31'h0, start_a}, 32'h1);
    chk("single_data", {24'h0, data_a}, 32'h35);
    chk("single_level_pop", {29'h0, lvl_a}, 32'd0);
    ticks(2);
    chk("single_start_held", {31'h0, start_a}, 32'h1);
    ticks(1);
    chk("single_start_ack", {31'h0, start_a}, 32'h0);
    btn = 1'b0;
    ticks(40);
    chk("single_start_count", nstart[0] - b0, 32'd1);
    chk("single_hex_count", nstart[1] - b1, 32'd1);
    chk("single_hex_data", {24'h0, lastd[1]}, 32'h35);

    // Bouncy button: only one press event.
    sw = 4'h0;
    ticks(4);
    b0 = nstart[0];
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      ticks(2);
    end
    press(12, 40);
    chk("bounce_start_count", nstart[0] - b0, 32'd1);
    chk("bounce_data", {24'h0, lastd[0]}, 32'h30);

    // Encoder table for both modes.
    for (int i = 0; i < 5; i++) begin
      sw = ev[i].sw;
      ticks(4);
      b0 = nstart[0];
      b1 = nstart[1];
      i0 = ninv[0];
      i1 = ninv[1];
      press(12, 40);
      chk($sformatf("enc%0d_dec_starts", i), nstart[0] - b0, ev[i].a_starts);
      if (ev[i].a_starts != 0)
        chk($sformatf("enc%0d_dec_data", i), {24'h0, lastd[0]}, {24'h0, ev[i].a_data});
      chk($sformatf("enc%0d_dec_invalid", i), ninv[0] - i0, ev[i].a_inv);
      chk($sformatf("enc%0d_hex_starts", i), nstart[1] - b1, 32'd1);
      chk($sformatf("enc%0d_hex_data", i), {24'h0, lastd[1]}, {24'h0, ev[i].h_data});
      chk($sformatf("enc%0d_hex_invalid", i), ninv[1] - i1, 32'd0);
    end

    // Auto-repeat with the serializer stuck busy: FIFO fills, then overflows.
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    bmode = 1;
    sw = 4'h3;
    ticks(4);
    b0 = nstart[0];
    o0 = novf[0];
    idx = 0;
    btn = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (idx < 14 && rv[idx].t == c) begin
        chk($sformatf("rpt_t%0d_level", c), {29'h0, lvl_a}, {29'h0, rv[idx].lvl});
        chk($sformatf("rpt_t%0d_overflow", c), {31'h0, ovf_a}, {31'h0, rv[idx].ovf});
        idx++;
      end
      if (c == 56) btn = 1'b0;
    end
    chk("rpt_overflow_count", novf[0] - o0, 32'd2);
    chk("rpt_no_start", nstart[0] - b0, 32'd0);
    chk("rpt_disabled_level", {29'h0, lvl_h}, 32'd1);

    // Serializer never acks: start held START_HOLD cycles, then next pop.
    t0 = ntmo[0];
    bmode = 2;
    cnt = 0;
    while (!start_a && cnt < 10) begin
      ticks(1);
      cnt++;
    end
    chk("tmo_start_seen", {31'h0, start_a}, 32'h1);
    chk("tmo_first_data", {24'h0, data_a}, 32'h33);
    cnt = 0;
    while (start_a && cnt < 30) begin
      cnt++;
      ticks(1);
    end
    chk("tmo_start_len", cnt, 32'd10);
    chk("tmo_pulse", {31'h0, tmo_a}, 32'h1);
    chk("tmo_level_after", {29'h0, lvl_a}, 32'd3);
    ticks(1);
    chk("tmo_next_start", {31'h0, start_a}, 32'h1);
    chk("tmo_pulse_single", {31'h0, tmo_a}, 32'h0);
    chk("tmo_next_level", {29'h0, lvl_a}, 32'd2);
    chk("tmo_count", ntmo[0] - t0, 32'd1);

    // Asynchronous reset in START with 2 entries queued.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_start", {31'h0, start_a}, 32'h0);
    chk("rstmid_level", {29'h0, lvl_a}, 32'd0);
    chk("rstmid_data", {24'h0, data_a}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bmode = 0;
    b0 = nstart[0];
    ticks(30);
    chk("rstmid_no_start", nstart[0] - b0, 32'd0);
    chk("rstmid_level_idle", {29'h0, lvl_a}, 32'd0);
    sw = 4'h7;
    ticks(4);
    press(12, 40);
    chk("rstmid_new_press", nstart[0] - b0, 32'd1);
    chk("rstmid_new_data", {24'h0, lastd[0]}, 32'h37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
